// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider controller.
//   state_t          : controller state (IDLE / RUN)
//   MIN_DIV          : smallest legal divisor
//   DEF_DIV_W        : default divisor/counter width
//   DEF_DEFAULT_DIV  : default divisor loaded at reset
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_DIV         = 2;
    localparam int DEF_DIV_W       = 8;
    localparam int DEF_DEFAULT_DIV = 3;

endpackage

// File: rtl/clk_div_ctrl_div_counter.sv
// Period counter for the clock divider.
//   clkin    : system clock
//   rst      : synchronous reset, active-high
//   clr      : force the count back to zero on the next edge
//   inc      : advance the count (ignored when clr is set)
//   n        : divisor in force
//   cnt      : current position within the period
//   terminal : last cycle of the period (cnt == n-1)
//   duty     : high half of the divided level (cnt < ceil(n/2))
module div_counter
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [DIV_W-1:0] n,
    output logic [DIV_W-1:0] cnt,
    output logic             terminal,
    output logic             duty
);

    // One extra bit so that n+1 cannot overflow at the maximum divisor.
    logic [DIV_W:0] half;

    always_ff @(posedge clkin) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        half     = ({1'b0, n} + 1'b1) >> 1;
        terminal = (cnt == n - 1'b1);
        duty     = ({1'b0, cnt} < half);
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable divide-by-N controller.
// Produces a one-cycle enable at the start of each divided period and a
// ~50% divided level. New divisors arrive over a valid/ready handshake,
// are held in a one-entry pending register and only take effect at a
// period boundary (or immediately while idle).
//   clkin     : system clock
//   rst       : synchronous reset, active-high
//   en        : run request (sampled in IDLE and at each terminal cycle)
//   cfg_valid : new divisor offered
//   cfg_div   : requested divisor
//   cfg_ready : pending slot free
//   cfg_err   : one-cycle pulse after an illegal divisor (<2) was dropped
//   clk_en    : one-cycle pulse at the start of each divided period
//   div_out   : divided level, high for ceil(N/2) of N cycles
//   cur_div   : divisor in force
//   running   : controller is in RUN
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_en,
    output logic             div_out,
    output logic [DIV_W-1:0] cur_div,
    output logic             running
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] LEGAL_MIN = DIV_W'(MIN_DIV);

    state_t           state;
    state_t           state_nxt;
    logic             pend_valid;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] cnt;
    logic             terminal;
    logic             duty;
    logic             accept;
    logic             load;
    logic             cnt_clr;

    // Period boundary: the counter restarts while idle and after each
    // terminal cycle; a pending divisor is only applied at those points.
    always_comb begin
        accept  = cfg_valid && cfg_ready;
        load    = pend_valid && ((state == IDLE) || terminal);
        cnt_clr = (state == IDLE) || terminal;
    end

    div_counter #(
        .DIV_W (DIV_W)
    ) u_div_counter (
        .clkin    (clkin),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (state == RUN),
        .n        (cur_div),
        .cnt      (cnt),
        .terminal (terminal),
        .duty     (duty)
    );

    // FSM state register
    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; en only matters in IDLE and at the terminal cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (terminal && !en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs, decoded directly from registered state
    always_comb begin
        running   = (state == RUN);
        clk_en    = (state == RUN) && (cnt == '0);
        div_out   = (state == RUN) && duty;
        cfg_ready = !pend_valid;
    end

    // Pending register, divisor in force and error pulse. accept needs
    // an empty slot and load needs a full one, so they never coincide.
    always_ff @(posedge clkin) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_div   <= '0;
            cur_div    <= RESET_DIV;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= accept && (cfg_div < LEGAL_MIN);
            if (accept && (cfg_div >= LEGAL_MIN)) begin
                pend_valid <= 1'b1;
                pend_div   <= cfg_div;
            end else if (load) begin
                pend_valid <= 1'b0;
                cur_div    <= pend_div;
            end
        end
    end

endmodule
